// File: rtl/divisor.sv
// divisor: sequential unsigned restoring (shift-subtract) divider.
// Produces one quotient bit per clock. St starts an operation from IDLE.
// Done pulses for one cycle when Quociente/Resto/DivZero have just been updated.
// A zero divisor finishes immediately with an all-ones quotient and Resto = Dividendo.
module divisor #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Dividendo,
  input  logic [WIDTH-1:0] Divisor,
  input  logic             St,
  output logic [WIDTH-1:0] Quociente,
  output logic [WIDTH-1:0] Resto,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  // The partial remainder is always < divisor, so its top bit is provably zero;
  // only the trial difference needs the extra bit.
  logic [WIDTH-1:0] r_rem;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;
  logic             w_div_zero;

  assign w_rem_sh   = {r_rem, r_q[WIDTH-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_d};
  assign w_rem_next = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_q_next   = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_div_zero = (Divisor == '0);

  assign Busy = (r_state == S_RUN);
  assign Done = (r_state == S_DONE);

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: start from IDLE, WIDTH steps in RUN, one cycle in DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (St) begin
          w_next_state = w_div_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, shift-subtract steps and result registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt     <= '0;
      r_q       <= '0;
      r_d       <= '0;
      r_rem     <= '0;
      Quociente <= '0;
      Resto     <= '0;
      DivZero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (St) begin
            r_q   <= Dividendo;
            r_d   <= Divisor;
            r_rem <= '0;
            r_cnt <= '0;
            if (w_div_zero) begin
              Quociente <= '1;
              Resto     <= Dividendo;
              DivZero   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          r_q   <= w_q_next;
          r_rem <= w_rem_next;
          if (w_last) begin
            Quociente <= w_q_next;
            Resto     <= w_rem_next;
            DivZero   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor.sv
module tb_divisor;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [W-1:0] Dividendo;
  logic [W-1:0] Divisor;
  logic         St;
  logic [W-1:0] Quociente;
  logic [W-1:0] Resto;
  logic         Busy;
  logic         Done;
  logic         DivZero;

  divisor #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Dividendo(Dividendo),
    .Divisor  (Divisor),
    .St       (St),
    .Quociente(Quociente),
    .Resto    (Resto),
    .Busy     (Busy),
    .Done     (Done),
    .DivZero  (DivZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           gap;
  } exp_t;

  exp_t sb[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_done = 0;

  logic [W-1:0] prev_q  = '0;
  logic [W-1:0] prev_r  = '0;
  logic         prev_dz = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
    exp_t e;
    e.a = a;
    e.b = b;
    e.gap = gap;
    if (b == 0) begin
      e.q  = {W{1'b1}};
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = W'(int'(a) / int'(b));
      e.r  = W'(int'(a) % int'(b));
      e.dz = 1'b0;
    end
    return e;
  endfunction

  always @(posedge Clk) cyc++;

  // Monitor: every Done pulse is matched against the oldest expected result.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset === 1'b1 && Done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: Done seen with empty scoreboard (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("quotient", 64'(Quociente), 64'(e.q));
        check("remainder", 64'(Resto), 64'(e.r));
        check("divzero", 64'(DivZero), 64'(e.dz));
        if (e.b != 0) begin
          check("invariant", 64'(Quociente) * 64'(e.b) + 64'(Resto), 64'(e.a));
          check("rem_lt_div", 64'(Resto < e.b), 64'd1);
        end
        if (e.gap != 0) check("done_gap", 64'(cyc - last_done), 64'(e.gap));
      end
      last_done = cyc;
    end
  end

  function automatic logic [W-1:0] rand_divisor();
    int unsigned sel;
    sel = $urandom_range(0, 15);
    if (sel == 0) return '0;
    if (sel < 4)  return W'($urandom_range(1, 15));
    return W'($urandom);
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
    exp_t e;
    int lat;
    int busy;
    bit seen;
    @(negedge Clk);
    Dividendo = a;
    Divisor   = b;
    St        = 1'b1;
    e = model(a, b, 0);
    sb.push_back(e);
    @(posedge Clk);
    #1;
    St   = 1'b0;
    lat  = 1;
    busy = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) begin
        seen = 1'b1;
        break;
      end
      if (Busy) busy++;
      if (i == 2 || i == 12) begin
        check("hold_q", 64'(Quociente), 64'(prev_q));
        check("hold_r", 64'(Resto), 64'(prev_r));
        check("hold_dz", 64'(DivZero), 64'(prev_dz));
      end
      if (disturb && i == 8) begin
        Dividendo = W'($urandom);
        Divisor   = W'($urandom);
        St        = 1'b1;
      end
      if (disturb && i == 9) St = 1'b0;
      @(posedge Clk);
      lat++;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(lat), (b == 0) ? 64'd1 : 64'(W + 1));
    check("busy_cycles", 64'(busy), (b == 0) ? 64'd0 : 64'(W));
    @(negedge Clk);
    check("done_one_cycle", 64'(Done), 64'd0);
    check("idle_not_busy", 64'(Busy), 64'd0);
    prev_q  = e.q;
    prev_r  = e.r;
    prev_dz = e.dz;
  endtask

  task automatic sweep(input int n);
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit seen;
    @(negedge Clk);
    a = W'($urandom);
    b = rand_divisor();
    Dividendo = a;
    Divisor   = b;
    St        = 1'b1;
    sb.push_back(model(a, b, 0));
    for (int k = 0; k < n; k++) begin
      seen = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(negedge Clk);
        if (Done) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sweep_timeout: no Done for op %0d", k);
        St = 1'b0;
        break;
      end
      if (k < n - 1) begin
        a = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
        b = rand_divisor();
        Dividendo = a;
        Divisor   = b;
        sb.push_back(model(a, b, (b == 0) ? 2 : W + 2));
      end else begin
        St = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset     = 1'b0;
    St        = 1'b0;
    Dividendo = '0;
    Divisor   = '0;
    #12;
    check("rst_q", 64'(Quociente), 64'd0);
    check("rst_r", 64'(Resto), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_dz", 64'(DivZero), 64'd0);
    @(negedge Clk);
    Reset = 1'b1;

    run_op(16'd100, 16'd7, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0);
    run_op(16'd3, 16'd10, 1'b0);
    run_op(16'd5, 16'd0, 1'b0);
    run_op(16'd9, 16'd3, 1'b0);
    run_op(16'd200, 16'd9, 1'b1);
    for (int i = 0; i < 6; i++) run_op(W'($urandom), rand_divisor(), 1'b1);

    // Asynchronous reset in the middle of an operation.
    @(negedge Clk);
    Dividendo = 16'hABCD;
    Divisor   = 16'h0013;
    St        = 1'b1;
    sb.push_back(model(16'hABCD, 16'h0013, 0));
    @(posedge Clk);
    #1;
    St = 1'b0;
    repeat (8) @(posedge Clk);
    #3;
    Reset = 1'b0;
    #1;
    check("midrst_q", 64'(Quociente), 64'd0);
    check("midrst_r", 64'(Resto), 64'd0);
    check("midrst_busy", 64'(Busy), 64'd0);
    check("midrst_done", 64'(Done), 64'd0);
    check("midrst_dz", 64'(DivZero), 64'd0);
    sb.delete();
    prev_q  = '0;
    prev_r  = '0;
    prev_dz = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    run_op(16'd1000, 16'd33, 1'b0);

    sweep(3000);
    repeat (4) @(negedge Clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
